fc_argmax_stream: RTL and testbench

//  Parametrised fully-connected output layer with argmax classification, successor of the fixed 32x10 FC unit.

---
 rtl/fc_pkg.sv | 38 +++
 rtl/fc_sat_mac.sv | 48 ++++
 rtl/fc_argmax_stream.sv | 144 ++++++++++++++
 tb/tb_fc_argmax_stream.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================
// fc_pkg : shared FSM encoding, index width and saturating add
// Rev 1.0
// ============================================================
package fc_pkg;

  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide signed add, clamped to the signed range of an acc_w-bit result.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int unsigned             acc_w
  );
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    hi  = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
    lo  = ~hi;
    if (sum > hi) return hi[SAT_W-1:0];
    if (sum < lo) return lo[SAT_W-1:0];
    return sum[SAT_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fc_sat_mac.sv
`default_nettype none
// ============================================================
// fc_sat_mac : one output lane, load-with-bias or accumulate, saturating
// Rev 1.0
// ============================================================
module fc_sat_mac import fc_pkg::*; #(
  parameter int IN_W      = 8,
  parameter int W_W       = 8,
  parameter int ACC_W     = 32,
  parameter int IN_SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [IN_W-1:0]  x_i,
  input  logic [W_W-1:0]   w_i,
  input  logic [ACC_W-1:0] bias_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [IN_W:0]       x_ext;
  logic [IN_W+W_W:0]   prod;
  logic [ACC_W-1:0]    base;

  always_comb begin
    x_ext = (IN_SIGNED != 0) ? {x_i[IN_W-1], x_i} : {1'b0, x_i};
    // Both operands sign-extended to the product width, so the low bits are the signed product.
    prod  = {{W_W{x_ext[IN_W]}}, x_ext} * {{(IN_W+1){w_i[W_W-1]}}, w_i};
    base  = load_i ? bias_i : acc_q;
    acc_d = acc_q;
    if (en_i) begin
      acc_d = ACC_W'(sat_add({{(SAT_W-ACC_W){base[ACC_W-1]}}, base},
                             {{(SAT_W-IN_W-W_W-1){prod[IN_W+W_W]}}, prod},
                             ACC_W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/fc_argmax_stream.sv
`default_nettype none
// ============================================================
// fc_argmax_stream : FC output layer, streamed logits and argmax class
// Rev 1.0
// ============================================================
module fc_argmax_stream import fc_pkg::*; #(
  parameter int IN_DIM    = 32,
  parameter int OUT_DIM   = 10,
  parameter int IN_W      = 8,
  parameter int W_W       = 8,
  parameter int ACC_W     = 32,
  parameter int IN_SIGNED = 0,
  parameter logic [OUT_DIM*IN_DIM*W_W-1:0] WEIGHTS = '0,
  parameter logic [OUT_DIM*ACC_W-1:0]      BIASES  = '0,
  localparam int IDX_W = idx_w(OUT_DIM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        class_out,
  output logic signed [ACC_W-1:0] class_max,
  output logic                    class_valid,
  output logic                    frame_err
);

  localparam int KW = idx_w(IN_DIM);

  state_e                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [IDX_W-1:0]        e_q, e_d;
  logic                    accept, hs, last_beat, last_logit, better;
  logic signed [ACC_W-1:0] acc [OUT_DIM];
  logic signed [ACC_W-1:0] run_max_q, class_max_q;
  logic [IDX_W-1:0]        run_idx_q, class_out_q;
  logic                    class_valid_q, frame_err_q;

  assign last_beat  = (k_q == KW'(IN_DIM - 1));
  assign last_logit = (e_q == IDX_W'(OUT_DIM - 1));
  assign accept     = in_valid & in_ready & ~clear;
  assign hs         = out_valid & out_ready & ~clear;
  assign better     = (e_q == '0) || (out_data > run_max_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = last_beat ? S_EMIT : S_ACC;
        S_ACC:   if (accept && last_beat) state_d = S_EMIT;
        S_EMIT:  if (hs && last_logit) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // in_ready is held low while reset is applied so every output reads 0 then.
  always_comb begin
    in_ready  = (state_q != S_EMIT) && !rst;
    out_valid = (state_q == S_EMIT);
    out_idx   = e_q;
    out_data  = out_valid ? acc[e_q] : '0;
  end

  always_comb begin
    k_d = k_q;
    e_d = e_q;
    if (clear) begin
      k_d = '0;
      e_d = '0;
    end else begin
      if (accept) k_d = last_beat ? '0 : k_q + KW'(1);
      if (hs)     e_d = last_logit ? '0 : e_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q           <= '0;
      e_q           <= '0;
      run_max_q     <= '0;
      run_idx_q     <= '0;
      class_max_q   <= '0;
      class_out_q   <= '0;
      class_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      k_q           <= k_d;
      e_q           <= e_d;
      class_valid_q <= 1'b0;
      frame_err_q   <= accept && (in_last != last_beat);
      if (hs) begin
        if (better) begin
          run_max_q <= out_data;
          run_idx_q <= e_q;
        end
        if (last_logit) begin
          class_valid_q <= 1'b1;
          class_out_q   <= better ? e_q : run_idx_q;
          class_max_q   <= better ? out_data : run_max_q;
        end
      end
    end
  end

  assign class_out   = class_out_q;
  assign class_max   = class_max_q;
  assign class_valid = class_valid_q;
  assign frame_err   = frame_err_q;

  for (genvar j = 0; j < OUT_DIM; j++) begin : g_lane
    logic [W_W-1:0] w_row [IN_DIM];
    for (genvar k = 0; k < IN_DIM; k++) begin : g_w
      assign w_row[k] = WEIGHTS[(j*IN_DIM + k)*W_W +: W_W];
    end
    fc_sat_mac #(
      .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W), .IN_SIGNED(IN_SIGNED)
    ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .en_i   (accept),
      .load_i (state_q == S_IDLE),
      .x_i    (in_data),
      .w_i    (w_row[k_q]),
      .bias_i (BIASES[j*ACC_W +: ACC_W]),
      .acc_o  (acc[j])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_argmax_stream.sv
`default_nettype none
// ============================================================
// tb_fc_argmax_stream : directed bench, four DUT configurations in lockstep
// Rev 1.0
// ============================================================
module tb_fc_argmax_stream;

  localparam int NI = 32;
  localparam int ND = 10;

  function automatic logic [ND*32-1:0] bias_idx();
    logic [ND*32-1:0] b;
    b = '0;
    for (int j = 0; j < ND; j++) b[j*32 +: 32] = 32'(j);
    return b;
  endfunction

  localparam logic [NI*ND*8-1:0] W_ONE = {(NI*ND){8'h01}};
  localparam logic [NI*ND*8-1:0] W_127 = {(NI*ND){8'h7f}};
  localparam logic [ND*32-1:0]   B_IDX = bias_idx();

  logic clk, rst, clear, in_valid, in_last, out_ready;
  logic [7:0] in_data;

  logic a_in_ready, a_out_valid, a_class_valid, a_frame_err;
  logic b_in_ready, b_out_valid, b_class_valid, b_frame_err;
  logic c_in_ready, c_out_valid, c_class_valid, c_frame_err;
  logic d_in_ready, d_out_valid, d_class_valid, d_frame_err;
  logic [3:0] a_out_idx, b_out_idx, c_out_idx, d_out_idx;
  logic [3:0] a_class_out, b_class_out, c_class_out, d_class_out;
  logic signed [31:0] a_out_data, c_out_data, d_out_data;
  logic signed [31:0] a_class_max, c_class_max, d_class_max;
  logic signed [15:0] b_out_data, b_class_max;

  int n_vec = 0;
  int n_err = 0;

  // A: W=1, bias=j. B: 16-bit acc, W=127. C: signed x, W=1. D: unsigned x, W=1.
  fc_argmax_stream #(.WEIGHTS(W_ONE), .BIASES(B_IDX)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(a_in_ready), .out_data(a_out_data), .out_idx(a_out_idx),
    .out_valid(a_out_valid), .out_ready(out_ready), .class_out(a_class_out),
    .class_max(a_class_max), .class_valid(a_class_valid), .frame_err(a_frame_err));

  fc_argmax_stream #(.ACC_W(16), .WEIGHTS(W_127), .BIASES('0)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(b_in_ready), .out_data(b_out_data), .out_idx(b_out_idx),
    .out_valid(b_out_valid), .out_ready(out_ready), .class_out(b_class_out),
    .class_max(b_class_max), .class_valid(b_class_valid), .frame_err(b_frame_err));

  fc_argmax_stream #(.IN_SIGNED(1), .WEIGHTS(W_ONE), .BIASES('0)) u_c (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(c_in_ready), .out_data(c_out_data), .out_idx(c_out_idx),
    .out_valid(c_out_valid), .out_ready(out_ready), .class_out(c_class_out),
    .class_max(c_class_max), .class_valid(c_class_valid), .frame_err(c_frame_err));

  fc_argmax_stream #(.WEIGHTS(W_ONE), .BIASES('0)) u_d (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(d_in_ready), .out_data(d_out_data), .out_idx(d_out_idx),
    .out_valid(d_out_valid), .out_ready(out_ready), .class_out(d_class_out),
    .class_max(d_class_max), .class_valid(d_class_valid), .frame_err(d_frame_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_frame(input logic [7:0] x, input int n, input int bad_last);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = x;
      in_last  = (k == NI-1) || (k == bad_last);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!a_out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_vec++;
    if ({a_in_ready, a_out_valid, a_class_valid, a_frame_err, a_out_idx, a_class_out} !== 12'd0
        || a_out_data !== 32'sd0 || a_class_max !== 32'sd0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%b ov=%b cv=%b fe=%b idx=%0d cls=%0d data=%0d max=%0d, want all 0",
               a_in_ready, a_out_valid, a_class_valid, a_frame_err, a_out_idx, a_class_out, a_out_data, a_class_max);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: a=%b b=%b, want 1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_basic();
    drive_frame(8'd1, NI, -1);
    for (int i = 0; i < ND; i++) begin
      wait_valid();
      n_vec++;
      if (a_out_valid !== 1'b1 || a_out_idx !== 4'(i) || a_out_data !== 32'(32 + i) || a_in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL basic_logit_a[%0d]: ov=%b idx=%0d data=%0d rdy=%b, want ov=1 idx=%0d data=%0d rdy=0",
                 i, a_out_valid, a_out_idx, a_out_data, a_in_ready, i, 32 + i);
      end
      n_vec++;
      if (d_out_data !== 32'sd32 || b_out_data !== 16'sd4064) begin
        n_err++;
        $display("FAIL basic_logit_bd[%0d]: d=%0d b=%0d, want d=32 b=4064", i, d_out_data, b_out_data);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (a_class_valid !== 1'b1 || a_class_out !== 4'd9 || a_class_max !== 32'sd41
        || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_class_a: cv=%b cls=%0d max=%0d ov=%b rdy=%b, want cv=1 cls=9 max=41 ov=0 rdy=1",
               a_class_valid, a_class_out, a_class_max, a_out_valid, a_in_ready);
    end
    n_vec++;
    if (d_class_out !== 4'd0 || d_class_max !== 32'sd32 || b_class_out !== 4'd0 || b_class_max !== 16'sd4064) begin
      n_err++;
      $display("FAIL basic_class_bd: d=%0d/%0d b=%0d/%0d, want d=0/32 b=0/4064",
               d_class_out, d_class_max, b_class_out, b_class_max);
    end
    @(posedge clk); #1;
    n_vec++;
    if (a_class_valid !== 1'b0 || a_class_out !== 4'd9 || a_class_max !== 32'sd41) begin
      n_err++;
      $display("FAIL basic_class_hold: cv=%b cls=%0d max=%0d, want cv=0 cls=9 max=41",
               a_class_valid, a_class_out, a_class_max);
    end
  endtask

  task automatic test_saturation();
    drive_frame(8'hFF, NI, -1);
    for (int i = 0; i < ND; i++) begin
      wait_valid();
      n_vec++;
      if (b_out_valid !== 1'b1 || b_out_idx !== 4'(i) || b_out_data !== 16'sd32767) begin
        n_err++;
        $display("FAIL sat_logit_b[%0d]: ov=%b idx=%0d data=%0d, want ov=1 idx=%0d data=32767",
                 i, b_out_valid, b_out_idx, b_out_data, i);
      end
      n_vec++;
      if (a_out_data !== 32'(8160 + i)) begin
        n_err++;
        $display("FAIL sat_logit_a[%0d]: data=%0d, want %0d", i, a_out_data, 8160 + i);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (b_class_valid !== 1'b1 || b_class_out !== 4'd0 || b_class_max !== 16'sd32767) begin
      n_err++;
      $display("FAIL sat_class_b: cv=%b cls=%0d max=%0d, want cv=1 cls=0 max=32767",
               b_class_valid, b_class_out, b_class_max);
    end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    int stall = 0;
    int guard = 0;
    drive_frame(8'd1, NI, -1);
    while (hs < ND && guard < 100) begin
      guard++;
      if (a_out_valid) begin
        out_ready = !(a_out_idx == 4'd4 && stall < 3);
        n_vec++;
        if (!out_ready) begin
          stall++;
          if (a_out_idx !== 4'd4 || a_out_data !== 32'sd36 || a_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_stall[%0d]: idx=%0d data=%0d rdy=%b, want idx=4 data=36 rdy=0",
                     stall, a_out_idx, a_out_data, a_in_ready);
          end
        end else begin
          if (a_out_idx !== 4'(hs) || a_out_data !== 32'(32 + hs) || a_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_logit[%0d]: idx=%0d data=%0d rdy=%b, want idx=%0d data=%0d rdy=0",
                     hs, a_out_idx, a_out_data, a_in_ready, hs, 32 + hs);
          end
          hs++;
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    n_vec++;
    if (hs != ND || stall != 3 || a_out_valid !== 1'b0 || a_class_valid !== 1'b1 || a_class_out !== 4'd9) begin
      n_err++;
      $display("FAIL bp_done: hs=%0d stalls=%0d ov=%b cv=%b cls=%0d, want hs=10 stalls=3 ov=0 cv=1 cls=9",
               hs, stall, a_out_valid, a_class_valid, a_class_out);
    end
  endtask

  task automatic test_signed();
    drive_frame(8'hFF, NI, -1);
    for (int i = 0; i < ND; i++) begin
      wait_valid();
      n_vec++;
      if (c_out_valid !== 1'b1 || c_out_data !== -32'sd32 || d_out_data !== 32'sd8160) begin
        n_err++;
        $display("FAIL signed_logit[%0d]: ov=%b c=%0d d=%0d, want ov=1 c=-32 d=8160",
                 i, c_out_valid, c_out_data, d_out_data);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (c_class_valid !== 1'b1 || c_class_out !== 4'd0 || c_class_max !== -32'sd32
        || d_class_out !== 4'd0 || d_class_max !== 32'sd8160) begin
      n_err++;
      $display("FAIL signed_class: cv=%b c=%0d/%0d d=%0d/%0d, want cv=1 c=0/-32 d=0/8160",
               c_class_valid, c_class_out, c_class_max, d_class_out, d_class_max);
    end
  endtask

  task automatic test_clear();
    drive_frame(8'd1, 10, -1);
    // A beat presented together with clear must be dropped.
    in_valid = 1'b1;
    in_data  = 8'd100;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_class_valid !== 1'b0) begin
      n_err++;
      $display("FAIL clear_state: ov=%b rdy=%b cv=%b, want ov=0 rdy=1 cv=0", a_out_valid, a_in_ready, a_class_valid);
    end
    drive_frame(8'd3, 7, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_frame(8'd1, NI, -1);
    for (int i = 0; i < ND; i++) begin
      wait_valid();
      n_vec++;
      if (a_out_valid !== 1'b1 || a_out_idx !== 4'(i) || a_out_data !== 32'(32 + i) || a_class_valid !== 1'b0) begin
        n_err++;
        $display("FAIL clear_logit[%0d]: ov=%b idx=%0d data=%0d cv=%b, want ov=1 idx=%0d data=%0d cv=0",
                 i, a_out_valid, a_out_idx, a_out_data, a_class_valid, i, 32 + i);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (a_class_valid !== 1'b1 || a_class_out !== 4'd9 || a_class_max !== 32'sd41) begin
      n_err++;
      $display("FAIL clear_class: cv=%b cls=%0d max=%0d, want cv=1 cls=9 max=41",
               a_class_valid, a_class_out, a_class_max);
    end
  endtask

  task automatic test_frame_err();
    for (int k = 0; k < NI; k++) begin
      in_valid = 1'b1;
      in_data  = 8'd1;
      in_last  = (k == 5) || (k == NI-1);
      @(posedge clk); #1;
      n_vec++;
      if (a_frame_err !== (k == 5)) begin
        n_err++;
        $display("FAIL frame_err_beat[%0d]: fe=%b, want %b", k, a_frame_err, (k == 5));
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < ND; i++) begin
      wait_valid();
      n_vec++;
      if (a_out_valid !== 1'b1 || a_out_idx !== 4'(i) || a_out_data !== 32'(32 + i)) begin
        n_err++;
        $display("FAIL frame_err_logit[%0d]: ov=%b idx=%0d data=%0d, want ov=1 idx=%0d data=%0d",
                 i, a_out_valid, a_out_idx, a_out_data, i, 32 + i);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (a_class_valid !== 1'b1 || a_class_out !== 4'd9 || a_class_max !== 32'sd41) begin
      n_err++;
      $display("FAIL frame_err_class: cv=%b cls=%0d max=%0d, want cv=1 cls=9 max=41",
               a_class_valid, a_class_out, a_class_max);
    end
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_data   = 8'd0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_signed();
    test_clear();
    test_frame_err();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
